// File: rtl/image_window_gen.sv
// Streaming 3x3 window generator: two row buffers plus a 3-column window register.
// Define WINDOW_GEN_SOF_EN to add the i_sof frame-realignment input.
module image_window_gen #(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
`ifdef WINDOW_GEN_SOF_EN
  input  logic        i_sof,
`endif
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_data_valid,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_frame_done
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [ColW-1:0] ColTwo  = ColW'(2);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
  localparam logic [RowW-1:0] RowOne  = RowW'(1);

  typedef enum logic {StFill, StActive} state_e;

  state_e          state_q, state_d, cur_state;
  logic [ColW-1:0] col_q, col_d, cur_col;
  logic [RowW-1:0] row_q, row_d, cur_row;
  logic [71:0]     win_q, win_d;
  logic [71:0]     data_q;
  logic            valid_q, done_q;
  logic            sof, emit, frame_end, last_col, last_row;
  logic [7:0]      rd0, rd1;

  logic [7:0] line0_q [IMG_WIDTH];
  logic [7:0] line1_q [IMG_WIDTH];

`ifdef WINDOW_GEN_SOF_EN
  assign sof = i_sof & i_pixel_data_valid;
`else
  assign sof = 1'b0;
`endif

  always_comb begin
    // A start-of-frame pixel is handled exactly as if the counters sat at (0,0) in FILL.
    cur_col   = sof ? '0 : col_q;
    cur_row   = sof ? '0 : row_q;
    cur_state = sof ? StFill : state_q;
    rd0       = line0_q[cur_col];
    rd1       = line1_q[cur_col];
    last_col  = (cur_col == ColLast);
    last_row  = (cur_row == RowLast);

    col_d     = col_q;
    row_d     = row_q;
    state_d   = state_q;
    win_d     = win_q;
    emit      = 1'b0;
    frame_end = 1'b0;

    if (i_pixel_data_valid) begin
      col_d   = last_col ? '0 : cur_col + ColW'(1);
      row_d   = cur_row;
      if (last_col) row_d = last_row ? '0 : cur_row + RowW'(1);
      state_d = cur_state;
      unique case (cur_state)
        StFill:   if (last_col && (cur_row == RowOne)) state_d = StActive;
        StActive: if (last_col && last_row) state_d = StFill;
        default:  state_d = StFill;
      endcase
      emit      = (cur_state == StActive) && (cur_col >= ColTwo);
      frame_end = emit && last_col && last_row;

      // Byte 3*wr+wc; shift columns left and insert {line1, line0, pixel} as column 2.
      for (int wr = 0; wr < 3; wr++) begin
        win_d[(3*wr)*8 +: 8]     = win_q[(3*wr+1)*8 +: 8];
        win_d[(3*wr+1)*8 +: 8]   = win_q[(3*wr+2)*8 +: 8];
      end
      win_d[2*8 +: 8] = rd1;
      win_d[5*8 +: 8] = rd0;
      win_d[8*8 +: 8] = i_pixel_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StFill;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= emit;
      done_q  <= frame_end;
      if (emit) data_q <= win_d;
    end
  end

  // Row buffers are never cleared; stale contents are masked by FILL and the col >= 2 rule.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_pixel_data_valid) begin
      line1_q[cur_col] <= rd0;
      line0_q[cur_col] <= i_pixel_data;
    end
  end

  assign o_pixel_data       = data_q;
  assign o_pixel_data_valid = valid_q;
  assign o_frame_done       = done_q;

endmodule

// File: tb/tb_image_window_gen.sv
// Directed bench for image_window_gen: a 4x4 instance and a 3x3 instance on one clock.
module tb_image_window_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  d4, d3;
  logic        v4, v3;
  logic        sof4, sof3;
  logic [71:0] o_data4, o_data3;
  logic        o_v4, o_v3, o_done4, o_done3;

  int          checks = 0;
  int          errors = 0;
  logic [71:0] exp_hold4 = '0;
  logic [71:0] first_win4, last_win4;

  always #5 clk = ~clk;

  image_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
    .i_clk              (clk),
    .i_rst              (rst),
`ifdef WINDOW_GEN_SOF_EN
    .i_sof              (sof4),
`endif
    .i_pixel_data       (d4),
    .i_pixel_data_valid (v4),
    .o_pixel_data       (o_data4),
    .o_pixel_data_valid (o_v4),
    .o_frame_done       (o_done4)
  );

  image_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) u_dut3 (
    .i_clk              (clk),
    .i_rst              (rst),
`ifdef WINDOW_GEN_SOF_EN
    .i_sof              (sof3),
`endif
    .i_pixel_data       (d3),
    .i_pixel_data_valid (v3),
    .o_pixel_data       (o_data3),
    .o_pixel_data_valid (o_v3),
    .o_frame_done       (o_done3)
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Expected window for a 4x4 frame whose pixel (r,c) carries base + 4r + c.
  function automatic logic [71:0] exp_win(input int base, input int rr, input int cc);
    logic [71:0] w;
    w = '0;
    for (int wr = 0; wr < 3; wr++)
      for (int wc = 0; wc < 3; wc++)
        w[(3*wr+wc)*8 +: 8] = 8'(base + 4*(rr-2+wr) + (cc-2+wc));
    return w;
  endfunction

  task automatic frame4(input int base, input bit gaps, input bit sof_first);
    int  r, c, ng;
    bit  ev;
    for (int i = 0; i < 16; i++) begin
      r    = i / 4;
      c    = i % 4;
      d4   = 8'(base + i);
      v4   = 1'b1;
      sof4 = sof_first && (i == 0);
      @(negedge clk);
      v4   = 1'b0;
      sof4 = 1'b0;
      ev   = (r >= 2) && (c >= 2);
      chk("valid4", {71'd0, o_v4}, {71'd0, ev});
      chk("done4", {71'd0, o_done4}, {71'd0, (i == 15)});
      if (ev) begin
        chk("win4", o_data4, exp_win(base, r, c));
        exp_hold4 = exp_win(base, r, c);
        if (r == 2 && c == 2) first_win4 = o_data4;
        if (r == 3 && c == 3) last_win4 = o_data4;
      end
      ng = !gaps ? 0 : (i == 3) ? 1 : (i == 7) ? 2 : (i == 10) ? 3 : 0;
      repeat (ng) begin
        @(negedge clk);
        chk("gap_valid4", {71'd0, o_v4}, 72'd0);
        chk("gap_hold4", o_data4, exp_hold4);
      end
    end
  endtask

  task automatic partial4(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      d4 = 8'(base + i);
      v4 = 1'b1;
      @(negedge clk);
      v4 = 1'b0;
      chk("part_valid4", {71'd0, o_v4}, 72'd0);
      chk("part_done4", {71'd0, o_done4}, 72'd0);
    end
  endtask

  initial begin
    rst = 1'b1; v4 = 1'b0; v3 = 1'b0; d4 = '0; d3 = '0; sof4 = 1'b0; sof3 = 1'b0;
    first_win4 = '0; last_win4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_data4", o_data4, 72'd0);
    chk("rst_valid4", {71'd0, o_v4}, 72'd0);
    chk("rst_done4", {71'd0, o_done4}, 72'd0);
    chk("rst_data3", o_data3, 72'd0);
    chk("rst_valid3", {71'd0, o_v3}, 72'd0);
    chk("rst_done3", {71'd0, o_done3}, 72'd0);
    rst = 1'b0;

    // Clean back-to-back frame.
    frame4(1, 1'b0, 1'b0);
    chk("first_win", first_win4, 72'h0B0A09070605030201);
    chk("last_win", last_win4, 72'h100F0E0C0B0A080706);

    // Same frame with input gaps.
    frame4(1, 1'b1, 1'b0);
    chk("gap_first_win", first_win4, 72'h0B0A09070605030201);
    chk("gap_last_win", last_win4, 72'h100F0E0C0B0A080706);

    // Two frames back-to-back; second must carry no stale bytes.
    frame4(1, 1'b0, 1'b0);
    frame4(17, 1'b0, 1'b0);
    chk("f2_first_win", first_win4, 72'h1B1A19171615131211);
    chk("f2_last_win", last_win4, 72'h201F1E1C1B1A181716);

    // Reset after pixel 10; the pixel presented with reset is dropped.
    partial4(1, 10);
    rst = 1'b1; v4 = 1'b1; d4 = 8'hAA;
    @(negedge clk);
    rst = 1'b0; v4 = 1'b0;
    chk("mid_rst_data4", o_data4, 72'd0);
    chk("mid_rst_valid4", {71'd0, o_v4}, 72'd0);
    chk("mid_rst_done4", {71'd0, o_done4}, 72'd0);
    exp_hold4 = '0;
    frame4(1, 1'b0, 1'b0);
    chk("post_rst_first", first_win4, 72'h0B0A09070605030201);
    chk("post_rst_last", last_win4, 72'h100F0E0C0B0A080706);

`ifdef WINDOW_GEN_SOF_EN
    // Abort after 5 pixels; the 6th pixel carries i_sof and starts a clean frame.
    partial4(1, 5);
    frame4(1, 1'b0, 1'b1);
    chk("sof_first", first_win4, 72'h0B0A09070605030201);
    chk("sof_last", last_win4, 72'h100F0E0C0B0A080706);
`endif

    // Minimum geometry: exactly one window.
    for (int i = 0; i < 9; i++) begin
      d3 = 8'(i + 1);
      v3 = 1'b1;
      @(negedge clk);
      v3 = 1'b0;
      chk("valid3", {71'd0, o_v3}, {71'd0, (i == 8)});
      chk("done3", {71'd0, o_done3}, {71'd0, (i == 8)});
      if (i == 8) chk("win3", o_data3, 72'h090807060504030201);
    end
    @(negedge clk);
    chk("valid3_after", {71'd0, o_v3}, 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
